// File: rtl/cache_controller.sv
// Write-through controller between the MEM stage, a 2-way 2-word-line data cache and a 64-bit SRAM.
// Read hits are served combinationally; misses fill a whole line; writes always go to SRAM.
module cache_controller #(
   parameter int ADDR_WIDTH       = 32,
   parameter int CACHE_ADDR_WIDTH = 19
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ADDR_WIDTH-1:0]       address,
   input  logic [31:0]                 wdata,
   input  logic                        MEM_R_EN,
   input  logic                        MEM_W_EN,
   output logic [31:0]                 rdata,
   output logic                        ready,
   output logic [CACHE_ADDR_WIDTH-1:0] cache_address,
   output logic [31:0]                 cache_in_data1,
   output logic [31:0]                 cache_in_data2,
   output logic                        cache_en_write,
   output logic                        cache_update_data,
   input  logic                        cache_hit,
   input  logic [31:0]                 cache_out_data,
   output logic [ADDR_WIDTH-1:0]       sram_address,
   output logic [31:0]                 sram_wdata,
   output logic                        sram_r_en,
   output logic                        sram_w_en,
   input  logic [63:0]                 sram_rdata,
   input  logic                        sram_ready
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      R_MISS = 3'd1,
      R_FILL = 3'd2,
      W_SIB  = 3'd3,
      W_SRAM = 3'd4,
      W_UPD  = 3'd5,
      W_DONE = 3'd6
   } state_t;

   state_t      r_state;
   logic [63:0] r_line;
   logic [31:0] r_sib;
   logic        r_hit;
   logic        r_sram_r_en;
   logic        r_sram_w_en;
   logic        r_cache_we;
   logic        r_cache_upd;

   // A simultaneous load and store is handled as a store.
   logic w_wr;
   logic w_rd;
   assign w_wr = MEM_W_EN;
   assign w_rd = MEM_R_EN & ~MEM_W_EN;

   // Strobes and SRAM enables are registered so the cache sees a clean single edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_line      <= '0;
         r_sib       <= '0;
         r_hit       <= 1'b0;
         r_sram_r_en <= 1'b0;
         r_sram_w_en <= 1'b0;
         r_cache_we  <= 1'b0;
         r_cache_upd <= 1'b0;
      end else begin
         r_cache_we  <= 1'b0;
         r_cache_upd <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_wr) begin
                  r_hit   <= cache_hit;
                  r_state <= W_SIB;
               end else if (w_rd && !cache_hit) begin
                  r_sram_r_en <= 1'b1;
                  r_state     <= R_MISS;
               end
            end
            R_MISS: begin
               if (sram_ready) begin
                  r_line      <= sram_rdata;
                  r_sram_r_en <= 1'b0;
                  r_cache_we  <= 1'b1;
                  r_state     <= R_FILL;
               end
            end
            R_FILL: r_state <= IDLE;
            W_SIB: begin
               r_sib       <= cache_out_data;
               r_sram_w_en <= 1'b1;
               r_state     <= W_SRAM;
            end
            W_SRAM: begin
               if (sram_ready) begin
                  r_sram_w_en <= 1'b0;
                  if (r_hit) begin
                     r_cache_we  <= 1'b1;
                     r_cache_upd <= 1'b1;
                     r_state     <= W_UPD;
                  end else begin
                     r_state <= W_DONE;
                  end
               end
            end
            W_UPD:   r_state <= IDLE;
            W_DONE:  r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign cache_en_write    = r_cache_we;
   assign cache_update_data = r_cache_upd;
   assign sram_r_en         = r_sram_r_en;
   assign sram_w_en         = r_sram_w_en;

   always_comb begin
      rdata          = '0;
      ready          = 1'b0;
      cache_address  = address[CACHE_ADDR_WIDTH-1:0];
      cache_in_data1 = '0;
      cache_in_data2 = '0;
      sram_address   = '0;
      sram_wdata     = '0;
      case (r_state)
         IDLE: begin
            ready = ~(w_wr | (w_rd & ~cache_hit));
            if (w_rd && cache_hit) rdata = cache_out_data;
         end
         R_MISS: sram_address = {address[ADDR_WIDTH-1:3], 3'b000};
         R_FILL: begin
            cache_in_data1 = r_line[31:0];
            cache_in_data2 = r_line[63:32];
            rdata          = address[2] ? r_line[63:32] : r_line[31:0];
            ready          = 1'b1;
         end
         // Read the other word of the line so a hit update can rewrite both words.
         W_SIB: cache_address = address[CACHE_ADDR_WIDTH-1:0] ^ CACHE_ADDR_WIDTH'(4);
         W_SRAM: begin
            sram_address = address;
            sram_wdata   = wdata;
         end
         W_UPD: begin
            cache_in_data1 = address[2] ? r_sib : wdata;
            cache_in_data2 = address[2] ? wdata : r_sib;
            ready          = 1'b1;
         end
         W_DONE:  ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a simple fixed-latency SRAM and a scripted cache.
module tb_cache_controller;

   logic        clk;
   logic        rst;
   logic [31:0] address;
   logic [31:0] wdata;
   logic        MEM_R_EN;
   logic        MEM_W_EN;
   logic [31:0] rdata;
   logic        ready;
   logic [18:0] cache_address;
   logic [31:0] cache_in_data1;
   logic [31:0] cache_in_data2;
   logic        cache_en_write;
   logic        cache_update_data;
   logic        cache_hit;
   logic [31:0] cache_out_data;
   logic [31:0] sram_address;
   logic [31:0] sram_wdata;
   logic        sram_r_en;
   logic        sram_w_en;
   logic [63:0] sram_rdata;
   logic        sram_ready;

   logic [31:0] w_word0;
   logic [31:0] w_word1;
   logic        r_mdl_rdy;
   logic        tb_pulse;
   int          mdl_cnt;
   int          lat;
   int          n_run;
   int          n_fail;
   int          n_we_edges;
   int          n_re_edges;
   int          n_wr_edges;
   logic [31:0] last_saddr;
   logic [31:0] last_swdata;
   logic [18:0] sib_caddr;

   cache_controller dut (
      .clk(clk), .rst(rst), .address(address), .wdata(wdata),
      .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .rdata(rdata), .ready(ready),
      .cache_address(cache_address), .cache_in_data1(cache_in_data1),
      .cache_in_data2(cache_in_data2), .cache_en_write(cache_en_write),
      .cache_update_data(cache_update_data), .cache_hit(cache_hit),
      .cache_out_data(cache_out_data), .sram_address(sram_address),
      .sram_wdata(sram_wdata), .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
      .sram_rdata(sram_rdata), .sram_ready(sram_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cache returns the word selected by address bit 2.
   assign cache_out_data = cache_address[2] ? w_word1 : w_word0;

   // SRAM pulses ready in the lat-th cycle its enable is held high.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mdl_cnt   <= 0;
         r_mdl_rdy <= 1'b0;
      end else if ((sram_r_en || sram_w_en) && !r_mdl_rdy) begin
         mdl_cnt   <= mdl_cnt + 1;
         r_mdl_rdy <= (mdl_cnt + 2 == lat);
      end else begin
         mdl_cnt   <= 0;
         r_mdl_rdy <= 1'b0;
      end
   end
   assign sram_ready = r_mdl_rdy | tb_pulse;

   initial n_we_edges = 0;
   initial n_re_edges = 0;
   initial n_wr_edges = 0;
   always @(posedge cache_en_write) n_we_edges++;
   always @(posedge sram_r_en) n_re_edges++;
   always @(posedge sram_w_en) n_wr_edges++;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic start(input logic [31:0] a, input logic [31:0] d, input logic rd,
                        input logic wr, input logic hit);
      @(negedge clk);
      address   = a;
      wdata     = d;
      MEM_R_EN  = rd;
      MEM_W_EN  = wr;
      cache_hit = hit;
      #1;
   endtask

   task automatic idle_req();
      @(negedge clk);
      MEM_R_EN = 1'b0;
      MEM_W_EN = 1'b0;
      #1;
   endtask

   // Advances until ready, returning stalled cycles and the cycle index of sram_ready.
   task automatic run_access(output int n_low, output int srdy_idx);
      int i;
      i        = 0;
      srdy_idx = -1;
      while (!ready && i < 200) begin
         if (sram_ready && srdy_idx < 0) srdy_idx = i;
         if (sram_r_en || sram_w_en) begin
            last_saddr  = sram_address;
            last_swdata = sram_wdata;
         end
         if (i == 1) sib_caddr = cache_address;
         @(negedge clk);
         #1;
         i++;
      end
      n_low = i;
      if (!ready) check("ready_timeout", 0, 1);
   endtask

   initial begin
      int n_low;
      int srdy;
      int e_we;
      int e_re;
      int e_wr;
      n_run     = 0;
      n_fail    = 0;
      rst       = 1'b1;
      address   = '0;
      wdata     = '0;
      MEM_R_EN  = 1'b0;
      MEM_W_EN  = 1'b0;
      cache_hit = 1'b0;
      w_word0   = '0;
      w_word1   = '0;
      tb_pulse  = 1'b0;
      lat       = 5;
      sram_rdata = 64'hBBBB_BBBB_AAAA_AAAA;
      last_saddr  = '0;
      last_swdata = '0;
      sib_caddr   = '0;

      repeat (2) @(negedge clk);
      #1;
      check("rst_ready", ready, 1);
      check("rst_rdata", rdata, 0);
      check("rst_sram_r_en", sram_r_en, 0);
      check("rst_en_write", cache_en_write, 0);
      @(negedge clk);
      rst = 1'b0;

      // Reset while a line read is outstanding.
      start(32'h0000_0104, 32'h0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      check("mid_sram_r_en", sram_r_en, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_r_en", sram_r_en, 0);
      check("mid_rst_en_write", cache_en_write, 0);
      MEM_R_EN = 1'b0;
      #1;
      check("mid_rst_ready", ready, 1);
      @(negedge clk);
      rst = 1'b0;
      e_we = n_we_edges;
      e_re = n_re_edges;
      @(negedge clk);
      tb_pulse = 1'b1;
      #1;
      check("stray_rdy_ready", ready, 1);
      @(negedge clk);
      tb_pulse = 1'b0;
      #1;
      check("stray_rdy_r_en", sram_r_en, 0);
      check("stray_rdy_we", n_we_edges - e_we, 0);
      check("stray_rdy_re", n_re_edges - e_re, 0);

      // Cold read miss of word 1.
      lat  = 5;
      e_we = n_we_edges;
      start(32'h0000_0104, 32'h0, 1'b1, 1'b0, 1'b0);
      run_access(n_low, srdy);
      check("miss_stall", n_low, 6);
      check("miss_sram_addr", last_saddr, 32'h0000_0100);
      check("fill_en_write", cache_en_write, 1);
      check("fill_update", cache_update_data, 0);
      check("fill_in1", cache_in_data1, 32'hAAAA_AAAA);
      check("fill_in2", cache_in_data2, 32'hBBBB_BBBB);
      check("miss_rdata", rdata, 32'hBBBB_BBBB);
      idle_req();
      check("fill_edges", n_we_edges - e_we, 1);
      check("post_fill_en", cache_en_write, 0);

      // Read hit of word 0.
      w_word0 = 32'hAAAA_AAAA;
      w_word1 = 32'hBBBB_BBBB;
      e_re    = n_re_edges;
      start(32'h0000_0100, 32'h0, 1'b1, 1'b0, 1'b1);
      check("hit_ready", ready, 1);
      check("hit_rdata", rdata, 32'hAAAA_AAAA);
      idle_req();
      check("hit_no_sram", n_re_edges - e_re, 0);
      check("idle_rdata", rdata, 0);

      // Write hit to word 0; sibling word 1 is preserved.
      lat  = 3;
      e_we = n_we_edges;
      start(32'h0000_0100, 32'h1234_5678, 1'b0, 1'b1, 1'b1);
      check("wr_ready_low", ready, 0);
      run_access(n_low, srdy);
      check("wr_stall", n_low, 5);
      check("wr_sib_addr", sib_caddr, 19'h00104);
      check("wr_sram_addr", last_saddr, 32'h0000_0100);
      check("wr_sram_data", last_swdata, 32'h1234_5678);
      check("upd_en_write", cache_en_write, 1);
      check("upd_update", cache_update_data, 1);
      check("upd_in1", cache_in_data1, 32'h1234_5678);
      check("upd_in2", cache_in_data2, 32'hBBBB_BBBB);
      idle_req();
      check("upd_edges", n_we_edges - e_we, 1);

      // Write miss: SRAM only, no cache write.
      lat  = 4;
      e_we = n_we_edges;
      start(32'h0000_0208, 32'hCAFE_0001, 1'b0, 1'b1, 1'b0);
      run_access(n_low, srdy);
      check("wmiss_stall", n_low, 6);
      check("wmiss_ready_after", n_low, srdy + 1);
      check("wmiss_sram_addr", last_saddr, 32'h0000_0208);
      check("wmiss_en_write", cache_en_write, 0);
      idle_req();
      check("wmiss_edges", n_we_edges - e_we, 0);
      check("wmiss_ready_idle", ready, 1);

      // Load and store together behave as a store.
      lat  = 3;
      e_re = n_re_edges;
      e_wr = n_wr_edges;
      start(32'h0000_0100, 32'h0BAD_F00D, 1'b1, 1'b1, 1'b1);
      check("both_ready_low", ready, 0);
      run_access(n_low, srdy);
      check("both_stall", n_low, 5);
      idle_req();
      check("both_w_en", n_wr_edges - e_wr, 1);
      check("both_no_r_en", n_re_edges - e_re, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
